// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the staged reset-release sequencer.
package rst_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GAP   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  // Width of the shared gap/timeout counter; never narrower than one bit
  function automatic int cnt_width(input int gap, input int timeout);
    int m;
    m = (gap > timeout) ? gap : timeout;
    return (m < 32'sd2) ? 32'sd1 : $clog2(m);
  endfunction

  // Width of a stage index; never narrower than one bit
  function automatic int idx_width(input int nstage);
    return (nstage < 32'sd2) ? 32'sd1 : $clog2(nstage);
  endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// Bundle between the sequencer and the reset domains it controls.
interface rst_sequencer_if
  import rst_seq_pkg::*;
#(
  parameter int NSTAGE = 4
) ();
  localparam int IDX_W = idx_width(NSTAGE);

  logic              rstgen;
  logic [NSTAGE-1:0] stage_done;
  logic [NSTAGE-1:0] stage_rst_n;
  logic              all_ready;
  logic              timeout_err;
  logic [IDX_W-1:0]  err_stage;

  // Sequencer side
  modport master (
    input  rstgen, stage_done,
    output stage_rst_n, all_ready, timeout_err, err_stage
  );

  // Reset generator / downstream domain side
  modport slave (
    output rstgen, stage_done,
    input  stage_rst_n, all_ready, timeout_err, err_stage
  );
endinterface

// File: rtl/rst_seq_timer.sv
// Clearable up-counter shared by the gap and the done-wait phases.
// hit is high while the count equals the compare value.
module rst_seq_timer #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] cmp,
  output logic         hit
);
  logic [W-1:0] cnt_r;

  // Count register: clear has priority over enable
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign hit = (cnt_r == cmp);
endmodule

// File: rtl/rst_sequencer.sv
// Staged reset-release sequencer: releases NSTAGE domains in order, one
// gap apart, waiting for each domain's done before moving on. A missing
// done raises a sticky timeout and returns every domain to reset.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NSTAGE  = 4,
  parameter int GAP     = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             nRST,
  rst_sequencer_if.master  bus
);
  localparam int IDX_W = idx_width(NSTAGE);
  localparam int CNT_W = cnt_width(GAP, TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSTAGE - 32'sd1);
  localparam logic [CNT_W-1:0] GAP_CMP  = CNT_W'(GAP - 32'sd1);
  localparam logic [CNT_W-1:0] TMO_CMP  = CNT_W'(TIMEOUT - 32'sd1);

  state_t            state_r, state_nxt_s;
  logic [IDX_W-1:0]  idx_r, idx_nxt_s;
  logic [NSTAGE-1:0] idx_oh_s;
  logic              done_s;

  logic              tmr_active_s, tmr_clr_s, tmr_en_s, tmr_hit_s;
  logic [CNT_W-1:0]  tmr_cmp_s;

  logic [NSTAGE-1:0] stage_rst_n_r, stage_rst_n_nxt_s;
  logic              all_ready_r, all_ready_nxt_s;
  logic              timeout_err_r, timeout_err_nxt_s;
  logic [IDX_W-1:0]  err_stage_r, err_stage_nxt_s;

  // Decode the current stage and pick out only its done bit
  always_comb begin
    done_s = 1'b0;
    for (int i = 0; i < NSTAGE; i++) begin
      idx_oh_s[i] = (idx_r == IDX_W'(i));
      done_s      = done_s | (bus.stage_done[i] & idx_oh_s[i]);
    end
  end

  // One counter serves both phases; it restarts on every state change
  assign tmr_cmp_s    = (state_r == ST_GAP) ? GAP_CMP : TMO_CMP;
  assign tmr_active_s = (state_r == ST_GAP) || (state_r == ST_WAIT);
  assign tmr_clr_s    = !tmr_active_s || (state_nxt_s != state_r);
  assign tmr_en_s     = !tmr_clr_s;

  rst_seq_timer #(.W(CNT_W)) u_timer (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (tmr_clr_s),
    .en   (tmr_en_s),
    .cmp  (tmr_cmp_s),
    .hit  (tmr_hit_s)
  );

  // State and stage index registers
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r <= ST_IDLE;
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Next state; a low rstgen sends everything back to IDLE from anywhere
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    if (!bus.rstgen) begin
      state_nxt_s = ST_IDLE;
      idx_nxt_s   = {IDX_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_GAP;
          idx_nxt_s   = {IDX_W{1'b0}};
        end
        ST_GAP: begin
          if (tmr_hit_s) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_GAP;
          end
        end
        ST_WAIT: begin
          // done wins over a timeout on the same edge
          if (done_s) begin
            if (idx_r == LAST_IDX) begin
              state_nxt_s = ST_RUN;
            end else begin
              state_nxt_s = ST_GAP;
              idx_nxt_s   = idx_r + IDX_W'(1'b1);
            end
          end else if (tmr_hit_s) begin
            state_nxt_s = ST_ERROR;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_RUN:   state_nxt_s = ST_RUN;
        ST_ERROR: state_nxt_s = ST_ERROR;
        default: begin
          state_nxt_s = ST_IDLE;
          idx_nxt_s   = {IDX_W{1'b0}};
        end
      endcase
    end
  end

  // Next output values, computed from the transition being taken
  always_comb begin
    stage_rst_n_nxt_s = stage_rst_n_r;
    all_ready_nxt_s   = all_ready_r;
    timeout_err_nxt_s = timeout_err_r;
    err_stage_nxt_s   = err_stage_r;
    if (!bus.rstgen) begin
      stage_rst_n_nxt_s = {NSTAGE{1'b0}};
      all_ready_nxt_s   = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          stage_rst_n_nxt_s = {NSTAGE{1'b0}};
          all_ready_nxt_s   = 1'b0;
        end
        ST_GAP: begin
          if (tmr_hit_s) begin
            stage_rst_n_nxt_s = stage_rst_n_r | idx_oh_s;
          end else begin
            stage_rst_n_nxt_s = stage_rst_n_r;
          end
        end
        ST_WAIT: begin
          if (done_s) begin
            if (idx_r == LAST_IDX) begin
              all_ready_nxt_s = 1'b1;
            end else begin
              all_ready_nxt_s = all_ready_r;
            end
          end else if (tmr_hit_s) begin
            stage_rst_n_nxt_s = {NSTAGE{1'b0}};
            timeout_err_nxt_s = 1'b1;
            err_stage_nxt_s   = idx_r;
          end else begin
            stage_rst_n_nxt_s = stage_rst_n_r;
          end
        end
        ST_RUN:   all_ready_nxt_s = all_ready_r;
        ST_ERROR: stage_rst_n_nxt_s = {NSTAGE{1'b0}};
        default: begin
          stage_rst_n_nxt_s = {NSTAGE{1'b0}};
          all_ready_nxt_s   = 1'b0;
        end
      endcase
    end
  end

  // Output registers; timeout flag and stage survive everything but nRST
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stage_rst_n_r <= {NSTAGE{1'b0}};
      all_ready_r   <= 1'b0;
      timeout_err_r <= 1'b0;
      err_stage_r   <= {IDX_W{1'b0}};
    end else begin
      stage_rst_n_r <= stage_rst_n_nxt_s;
      all_ready_r   <= all_ready_nxt_s;
      timeout_err_r <= timeout_err_nxt_s;
      err_stage_r   <= err_stage_nxt_s;
    end
  end

  assign bus.stage_rst_n = stage_rst_n_r;
  assign bus.all_ready   = all_ready_r;
  assign bus.timeout_err = timeout_err_r;
  assign bus.err_stage   = err_stage_r;
endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer (NSTAGE=4, GAP=16, TIMEOUT=100).
// Expected output snapshots are queued with the edge they belong to and
// checked 1 time unit after that edge.
module tb_rst_sequencer;
  localparam int NS    = 4;
  localparam int GAP_P = 16;
  localparam int TMO_P = 100;

  logic CLK;
  logic nRST;
  int   edge_cnt;
  int   errors;
  int   checks;
  logic       exp_terr;
  logic [1:0] exp_es;

  typedef struct {
    int         at_edge;
    string      tag;
    logic [3:0] rst_n;
    logic       rdy;
    logic       terr;
    logic [1:0] es;
  } exp_t;

  exp_t sb_q[$];

  rst_sequencer_if #(.NSTAGE(NS)) bus ();

  rst_sequencer #(.NSTAGE(NS), .GAP(GAP_P), .TIMEOUT(TMO_P)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [3:0] therm(input int n);
    logic [3:0] t;
    t = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      if (b < n) t[b] = 1'b1;
    end
    return t;
  endfunction

  task automatic push(input int at, input logic [3:0] rn, input logic rdy, input string tag);
    exp_t e;
    e.at_edge = at;
    e.tag     = tag;
    e.rst_n   = rn;
    e.rdy     = rdy;
    e.terr    = exp_terr;
    e.es      = exp_es;
    sb_q.push_back(e);
  endtask

  task automatic check_due();
    exp_t e;
    logic [7:0] obs, exp_v;
    while (sb_q.size() > 0 && sb_q[0].at_edge <= edge_cnt) begin
      e = sb_q.pop_front();
      checks++;
      obs   = {bus.stage_rst_n, bus.all_ready, bus.timeout_err, bus.err_stage};
      exp_v = {e.rst_n, e.rdy, e.terr, e.es};
      assert (obs === exp_v && e.at_edge == edge_cnt) else begin
        errors++;
        $error("FAIL %s @edge %0d (due %0d): observed rst_n=%b rdy=%b terr=%b es=%0d, expected rst_n=%b rdy=%b terr=%b es=%0d",
               e.tag, edge_cnt, e.at_edge, bus.stage_rst_n, bus.all_ready, bus.timeout_err,
               bus.err_stage, e.rst_n, e.rdy, e.terr, e.es);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    edge_cnt++;
    #1;
    check_due();
  endtask

  task automatic run_to(input int n);
    while (edge_cnt < n) tick();
  endtask

  // Drop rstgen for one edge, then raise it; e0 is the edge that samples it high
  task automatic restart(output int e0);
    bus.rstgen     = 1'b0;
    bus.stage_done = 4'b0000;
    push(edge_cnt + 1, 4'b0000, 1'b0, "rstgen_drop");
    tick();
    bus.rstgen = 1'b1;
    e0 = edge_cnt + 1;
  endtask

  // Full sequence from e0; stage 'skip' never acks; stage 0 acks ack0 edges after release
  task automatic run_sequence(input int e0, input int skip, input int ack0);
    int rel;
    int ack;
    rel = e0 + GAP_P;
    for (int i = 0; i < NS; i++) begin
      ack = (i == 0) ? ack0 : 3;
      push(rel - 1, therm(i), 1'b0, "pre_release");
      push(rel, therm(i + 1), 1'b0, "release");
      if (i == skip) begin
        push(rel + TMO_P - 1, therm(i + 1), 1'b0, "pre_timeout");
        exp_terr = 1'b1;
        exp_es   = 2'(i);
        push(rel + TMO_P, 4'b0000, 1'b0, "timeout");
        push(rel + TMO_P + 20, 4'b0000, 1'b0, "error_hold");
        run_to(rel + TMO_P + 20);
        return;
      end
      if (i == NS - 1) begin
        run_to(rel + ack - 1);
        bus.stage_done[i] = 1'b1;
        push(rel + ack, therm(NS), 1'b1, "all_ready");
        push(rel + ack + 10, therm(NS), 1'b1, "run_hold");
        run_to(rel + ack + 1);
        bus.stage_done = 4'b0000;
        run_to(rel + ack + 10);
      end else begin
        push(rel + ack, therm(i + 1), 1'b0, "ack");
        run_to(rel + ack - 1);
        bus.stage_done[i] = 1'b1;
        rel = rel + ack + GAP_P;
      end
    end
  endtask

  initial begin
    int e0;
    edge_cnt       = 0;
    errors         = 0;
    checks         = 0;
    exp_terr       = 1'b0;
    exp_es         = 2'd0;
    nRST           = 1'b0;
    bus.rstgen     = 1'b1;
    bus.stage_done = 4'b0000;

    // 1: reset held with rstgen high
    for (int k = 0; k < 3; k++) begin
      push(edge_cnt + 1, 4'b0000, 1'b0, "reset");
      tick();
    end
    nRST       = 1'b1;
    bus.rstgen = 1'b0;
    push(edge_cnt + 2, 4'b0000, 1'b0, "idle_no_rstgen");
    run_to(edge_cnt + 2);

    // 2: normal sequence, releases at e16/e35/e54/e73, all_ready at e76
    bus.rstgen = 1'b1;
    e0 = edge_cnt + 1;
    run_sequence(e0, NS, 3);

    // 5: stage 0 acks exactly on the 100th WAIT edge
    restart(e0);
    run_sequence(e0, NS, TMO_P);

    // 3: stage 2 never acks
    restart(e0);
    run_sequence(e0, 2, 3);

    // 4: rstgen dropped while waiting on stage 1, then re-raised
    restart(e0);
    push(e0 + 16, 4'b0001, 1'b0, "w1_release0");
    run_to(e0 + 18);
    bus.stage_done[0] = 1'b1;
    push(e0 + 35, 4'b0011, 1'b0, "w1_release1");
    run_to(e0 + 39);
    bus.rstgen     = 1'b0;
    bus.stage_done = 4'b0000;
    push(e0 + 40, 4'b0000, 1'b0, "drop_in_wait");
    run_to(e0 + 42);
    bus.rstgen = 1'b1;
    e0 = edge_cnt + 1;
    run_sequence(e0, NS, 3);

    // 6: nRST pulse in RUN after a timeout clears everything, then restarts
    nRST     = 1'b0;
    exp_terr = 1'b0;
    exp_es   = 2'd0;
    push(edge_cnt + 1, 4'b0000, 1'b0, "nrst_in_run");
    tick();
    nRST = 1'b1;
    e0 = edge_cnt + 1;
    run_sequence(e0, NS, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Staged reset-release sequencer that sits directly downstream of the power-on reset generator. Once the generator's `rstgen` output (PLL locked and settled) is high, it takes NSTAGE downstream domains out of reset one at a time. Each release is separated by a fixed gap, and each stage must acknowledge with a done handshake before the next stage is released. A missing acknowledgement is reported as a timeout, and all stages are returned to reset.

## Interface
Parameters:
- NSTAGE, 4, number of sequenced stages; legal range 2..8
- GAP, 16, cycles from entering the gap phase to releasing the current stage; must be ≥1
- TIMEOUT, 1024, maximum cycles spent waiting for a stage's done; must be ≥1

Ports:
- CLK  in  1  system clock; the block has one clock
- nRST  in  1  reset; synchronous, active-low
- rstgen  in  1  "system ready" from the reset generator; level-sensitive
- stage_done  in  NSTAGE  per-stage init-complete acknowledgement, level
- stage_rst_n  out  NSTAGE  per-stage active-low reset; bit i drives stage i
- all_ready  out  1  high when every stage is released and acknowledged
- timeout_err  out  1  sticky timeout flag
- err_stage  out  clog2(NSTAGE)  index of the stage that last timed out

## Operation
- State machine with five states:
  - IDLE: all stage_rst_n are 0. If rstgen=1, go to GAP with idx=0 and cnt=0.
  - GAP: cnt increments each cycle. At the edge where cnt==GAP-1, set stage_rst_n[idx]=1, go to WAIT, and clear cnt.
  - WAIT: the block samples only stage_done[idx]; all other done bits are ignored.
    - If stage_done[idx]=1 and idx<NSTAGE-1: idx++, go to GAP, clear cnt.
    - If stage_done[idx]=1 and idx==NSTAGE-1: go to RUN and set all_ready=1.
    - Else if cnt==TIMEOUT-1: go to ERROR.
    - Else cnt++.
  - RUN: outputs are held. stage_done is ignored.
  - ERROR: on entry, set timeout_err=1 and err_stage=idx, and drive all stage_rst_n to 0. The block stays in ERROR until rstgen=0.
- rstgen=0 in any state: at the next edge, go to IDLE, set all stage_rst_n=0, all_ready=0, idx=0. timeout_err and err_stage are unchanged.
- A rising rstgen always restarts the sequence from stage 0 with a full GAP.
- nRST=0 overrides everything else. Values at reset:
  - state=IDLE, idx=0, cnt=0
  - stage_rst_n=0, all_ready=0, timeout_err=0, err_stage=0
- Stages are released in order; stage_rst_n is therefore always a thermometer code from bit 0 upward.
- All outputs are registered.

## Timing
- If rstgen is first sampled high at edge e0, stage_rst_n[0] rises at edge e0+GAP.
- A done sampled high at edge d enters GAP at d; the next stage is released at d+GAP.
- all_ready rises at the same edge that samples stage_done[NSTAGE-1]=1.
- Timeout: the ERROR transition happens at the TIMEOUT-th edge in WAIT that samples done low.
- If done is high at the edge where cnt==TIMEOUT-1, done wins and no error is raised.
- Response to rstgen falling and to a synchronous nRST: 1 cycle; outputs are updated at that same edge.
- Counter width is clog2(max(GAP, TIMEOUT)). The counter never wraps, because it is cleared on every state change.

## Structure
- Package `rst_seq_pkg` holds:
  - the state enum {IDLE, GAP, WAIT, RUN, ERROR}
  - a helper function for the counter width
- One sub-module, `rst_seq_timer`: a clearable up-counter with a `hit` output for a compare value. It is instantiated once and shared by GAP and WAIT, with the compare value muxed on state.

## Test plan
Parameters for all tests: NSTAGE=4, GAP=16, TIMEOUT=100.
1. nRST low for 3 cycles with rstgen=1 → stage_rst_n=4'b0000, all_ready=0, timeout_err=0, err_stage=0 throughout.
2. rstgen sampled high at e0, bench raises stage_done[i] 3 cycles after each release:
   - stage_rst_n bits rise at e16, e35, e54 and e73
   - all_ready rises at e76
3. Same as test 2, but stage_done[2] is never raised:
   - at e54+100=e154: timeout_err=1, err_stage=2, stage_rst_n=0000
   - state stays ERROR while rstgen=1
4. rstgen dropped while waiting on stage 1:
   - next edge: stage_rst_n=0000
   - rstgen re-raised at edge r: stage_rst_n[0] rises at r+16
5. stage_done[0] raised exactly at the 100th WAIT edge → stage advances to 1, and timeout_err stays 0.
6. nRST pulsed while in RUN, after an earlier timeout → all outputs 0 at that edge including timeout_err; with rstgen still high, the sequence restarts.
